// File: rtl/retire_ctrl.sv
// retire_ctrl: commit-stage sequencer behind the 3-wide reorder buffer.
// Commits up to three retiring slots per cycle to the architectural map,
// stops at the oldest slot needing recovery or halt, and sequences
// RECOVER (flush + redirect) -> DRAIN -> RUN, or latches HALT.
// Optional statistics counters are built when RETIRE_STATS_EN is defined.
//
// Handshake note: there is no backpressure on the retire interface. Each
// i_ret_valid bit qualifies its slot for one cycle; o_dispatch_hold tells
// the front end to stop dispatching, and while it is high the ret_* inputs
// are ignored. o_recover_en / o_redirect_valid are single-cycle pulses.
module retire_ctrl #(
   parameter int XLEN         = 32,
   parameter int ARCH_W       = 5,
   parameter int PHYS_W       = 6,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [2:0]                  i_ret_valid,
   input  logic [2:0][ARCH_W-1:0]      i_ret_arch,
   input  logic [2:0][PHYS_W-1:0]      i_ret_phys,
   input  logic [2:0]                  i_ret_precise,
   input  logic [2:0][XLEN-1:0]        i_ret_target_pc,
   input  logic [2:0]                  i_ret_halt,
   input  logic                        i_sq_busy,
   output logic [2:0]                  o_map_we,
   output logic [2:0][ARCH_W-1:0]      o_map_arch,
   output logic [2:0][PHYS_W-1:0]      o_map_phys,
   output logic                        o_recover_en,
   output logic                        o_redirect_valid,
   output logic [XLEN-1:0]             o_redirect_pc,
   output logic                        o_dispatch_hold,
   output logic                        o_halted,
`ifdef RETIRE_STATS_EN
   output logic [63:0]                 o_stat_retired,
   output logic [31:0]                 o_stat_recovers,
`endif
   output logic [1:0]                  o_dbg_state
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RECOVER = 2'd1,
      DRAIN   = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t                   r_state;
   logic [3:0]               r_drain_cnt;
   logic [2:0]               r_map_we;
   logic [2:0][ARCH_W-1:0]   r_map_arch;
   logic [2:0][PHYS_W-1:0]   r_map_phys;
   logic                     r_recover_en;
   logic                     r_redirect_valid;
   logic [XLEN-1:0]          r_redirect_pc;
   logic                     r_dispatch_hold;
   logic                     r_halted;
`ifdef RETIRE_STATS_EN
   logic [63:0]              r_stat_retired;
   logic [31:0]              r_stat_recovers;
`endif

   logic [2:0]               w_eff;
   logic                     w_found;
   logic [1:0]               w_sel;
   logic [2:0]               w_we;
   logic [2:0][ARCH_W-1:0]   w_arch;
   logic [2:0][PHYS_W-1:0]   w_phys;
   logic [1:0]               w_n_ret;

   // Oldest-first scan: slots from 2 down to the first valid precise/halt slot are effective.
   always_comb begin
      w_eff   = 3'b000;
      w_found = 1'b0;
      w_sel   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (!w_found) begin
            w_eff[i] = 1'b1;
            if (i_ret_valid[i] && (i_ret_precise[i] || i_ret_halt[i])) begin
               w_found = 1'b1;
               w_sel   = 2'(i);
            end
         end
      end
   end

   // Per-slot map write; index/data are zeroed when the slot does not write.
   always_comb begin
      w_we   = 3'b000;
      w_arch = '0;
      w_phys = '0;
      for (int i = 0; i < 3; i++) begin
         w_we[i] = w_eff[i] && i_ret_valid[i] && (i_ret_arch[i] != '0);
         if (w_we[i]) begin
            w_arch[i] = i_ret_arch[i];
            w_phys[i] = i_ret_phys[i];
         end
      end
      w_n_ret = 2'(32'(w_eff[0] & i_ret_valid[0]) + 32'(w_eff[1] & i_ret_valid[1])
                    + 32'(w_eff[2] & i_ret_valid[2]));
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= RUN;
         r_drain_cnt      <= 4'd0;
         r_map_we         <= 3'b000;
         r_map_arch       <= '0;
         r_map_phys       <= '0;
         r_recover_en     <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_dispatch_hold  <= 1'b0;
         r_halted         <= 1'b0;
`ifdef RETIRE_STATS_EN
         r_stat_retired   <= 64'd0;
         r_stat_recovers  <= 32'd0;
`endif
      end else begin
         r_map_we         <= 3'b000;
         r_map_arch       <= '0;
         r_map_phys       <= '0;
         r_recover_en     <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            RUN: begin
               r_map_we   <= w_we;
               r_map_arch <= w_arch;
               r_map_phys <= w_phys;
`ifdef RETIRE_STATS_EN
               r_stat_retired <= r_stat_retired + 64'(w_n_ret);
`endif
               if (w_found) begin
                  r_dispatch_hold <= 1'b1;
                  // Halt dominates precise on the same slot.
                  if (i_ret_halt[w_sel]) begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state          <= RECOVER;
                     r_recover_en     <= 1'b1;
                     r_redirect_valid <= 1'b1;
                     r_redirect_pc    <= i_ret_target_pc[w_sel];
`ifdef RETIRE_STATS_EN
                     r_stat_recovers  <= r_stat_recovers + 32'd1;
`endif
                  end
               end
            end
            RECOVER: begin
               r_state     <= DRAIN;
               r_drain_cnt <= 4'(DRAIN_CYCLES);
            end
            DRAIN: begin
               if (r_drain_cnt != 4'd0) begin
                  r_drain_cnt <= r_drain_cnt - 4'd1;
               end else if (!i_sq_busy) begin
                  r_state         <= RUN;
                  r_dispatch_hold <= 1'b0;
               end
            end
            default: begin
               // HALT is absorbing until reset.
               r_state <= HALT;
            end
         endcase
      end
   end

   assign o_map_we         = r_map_we;
   assign o_map_arch       = r_map_arch;
   assign o_map_phys       = r_map_phys;
   assign o_recover_en     = r_recover_en;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_dispatch_hold  = r_dispatch_hold;
   assign o_halted         = r_halted;
   assign o_dbg_state      = r_state;
`ifdef RETIRE_STATS_EN
   assign o_stat_retired   = r_stat_retired;
   assign o_stat_recovers  = r_stat_recovers;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed testbench for retire_ctrl (default parameters).
module tb_retire_ctrl;

   localparam int XLEN   = 32;
   localparam int ARCH_W = 5;
   localparam int PHYS_W = 6;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_RECOVER = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_HALT    = 2'd3;

   logic                     clock;
   logic                     reset;
   logic [2:0]               ret_valid;
   logic [2:0][ARCH_W-1:0]   ret_arch;
   logic [2:0][PHYS_W-1:0]   ret_phys;
   logic [2:0]               ret_precise;
   logic [2:0][XLEN-1:0]     ret_target_pc;
   logic [2:0]               ret_halt;
   logic                     sq_busy;
   logic [2:0]               map_we;
   logic [2:0][ARCH_W-1:0]   map_arch;
   logic [2:0][PHYS_W-1:0]   map_phys;
   logic                     recover_en;
   logic                     redirect_valid;
   logic [XLEN-1:0]          redirect_pc;
   logic                     dispatch_hold;
   logic                     halted;
   logic [1:0]               dbg_state;
`ifdef RETIRE_STATS_EN
   logic [63:0]              stat_retired;
   logic [31:0]              stat_recovers;
`endif

   int n_cmp;
   int n_err;

   retire_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .i_ret_valid      (ret_valid),
      .i_ret_arch       (ret_arch),
      .i_ret_phys       (ret_phys),
      .i_ret_precise    (ret_precise),
      .i_ret_target_pc  (ret_target_pc),
      .i_ret_halt       (ret_halt),
      .i_sq_busy        (sq_busy),
      .o_map_we         (map_we),
      .o_map_arch       (map_arch),
      .o_map_phys       (map_phys),
      .o_recover_en     (recover_en),
      .o_redirect_valid (redirect_valid),
      .o_redirect_pc    (redirect_pc),
      .o_dispatch_hold  (dispatch_hold),
      .o_halted         (halted),
`ifdef RETIRE_STATS_EN
      .o_stat_retired   (stat_retired),
      .o_stat_recovers  (stat_recovers),
`endif
      .o_dbg_state      (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ret_valid     = 3'b000;
      ret_arch      = '0;
      ret_phys      = '0;
      ret_precise   = 3'b000;
      ret_target_pc = '0;
      ret_halt      = 3'b000;
   endtask

   task automatic set_slot(input int s, input logic [ARCH_W-1:0] a, input logic [PHYS_W-1:0] p,
                           input logic pr, input logic h, input logic [XLEN-1:0] pc);
      ret_valid[s]     = 1'b1;
      ret_arch[s]      = a;
      ret_phys[s]      = p;
      ret_precise[s]   = pr;
      ret_halt[s]      = h;
      ret_target_pc[s] = pc;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      sq_busy = 1'b0;
      do_reset();

      // Reset state
      check("rst_map_we", 64'(map_we), 64'd0);
      check("rst_map_arch", 64'(map_arch), 64'd0);
      check("rst_map_phys", 64'(map_phys), 64'd0);
      check("rst_recover", 64'(recover_en), 64'd0);
      check("rst_redir_v", 64'(redirect_valid), 64'd0);
      check("rst_redir_pc", 64'(redirect_pc), 64'd0);
      check("rst_hold", 64'(dispatch_hold), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(S_RUN));

      // Plain commit, slot 1 has arch 0 -> no write
      idle();
      set_slot(2, 5'd3, 6'd33, 1'b0, 1'b0, 32'h0);
      set_slot(1, 5'd0, 6'd34, 1'b0, 1'b0, 32'h0);
      set_slot(0, 5'd7, 6'd35, 1'b0, 1'b0, 32'h0);
      tick();
      check("a_we", 64'(map_we), 64'b101);
      check("a_arch2", 64'(map_arch[2]), 64'd3);
      check("a_phys2", 64'(map_phys[2]), 64'd33);
      check("a_arch1", 64'(map_arch[1]), 64'd0);
      check("a_phys1", 64'(map_phys[1]), 64'd0);
      check("a_arch0", 64'(map_arch[0]), 64'd7);
      check("a_phys0", 64'(map_phys[0]), 64'd35);
      check("a_hold", 64'(dispatch_hold), 64'd0);
      check("a_recover", 64'(recover_en), 64'd0);

      // Precise on slot 1, store queue busy through the drain
      idle();
      set_slot(2, 5'd1, 6'd10, 1'b0, 1'b0, 32'h0);
      set_slot(1, 5'd2, 6'd11, 1'b1, 1'b0, 32'h1000);
      set_slot(0, 5'd3, 6'd12, 1'b0, 1'b0, 32'h0);
      sq_busy = 1'b1;
      tick();
      check("b_we", 64'(map_we), 64'b110);
      check("b_arch1", 64'(map_arch[1]), 64'd2);
      check("b_phys1", 64'(map_phys[1]), 64'd11);
      check("b_recover", 64'(recover_en), 64'd1);
      check("b_redir_v", 64'(redirect_valid), 64'd1);
      check("b_redir_pc", 64'(redirect_pc), 64'h1000);
      check("b_hold", 64'(dispatch_hold), 64'd1);
      check("b_state", 64'(dbg_state), 64'(S_RECOVER));
      // Traffic during RECOVER/DRAIN must be ignored
      idle();
      set_slot(2, 5'd5, 6'd21, 1'b1, 1'b0, 32'hdead);
      set_slot(0, 5'd6, 6'd22, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("c_recover", 64'(recover_en), 64'd0);
         check("c_redir_v", 64'(redirect_valid), 64'd0);
         check("c_we", 64'(map_we), 64'd0);
         check("c_hold", 64'(dispatch_hold), 64'd1);
         check("c_state", 64'(dbg_state), 64'(S_DRAIN));
      end
      sq_busy = 1'b0;
      tick();
      check("c_exit_hold", 64'(dispatch_hold), 64'd0);
      check("c_exit_state", 64'(dbg_state), 64'(S_RUN));
      check("c_exit_we", 64'(map_we), 64'd0);

      // Back-to-back: precise on slot 2 in the first RUN cycle
      idle();
      set_slot(2, 5'd6, 6'd20, 1'b1, 1'b0, 32'h2000);
      set_slot(1, 5'd9, 6'd23, 1'b0, 1'b0, 32'h0);
      tick();
      check("bb_recover", 64'(recover_en), 64'd1);
      check("bb_redir_pc", 64'(redirect_pc), 64'h2000);
      check("bb_we", 64'(map_we), 64'b100);
      check("bb_phys2", 64'(map_phys[2]), 64'd20);
      idle();
      tick();
      check("bb_d1_state", 64'(dbg_state), 64'(S_DRAIN));
      tick();
      check("bb_d2_hold", 64'(dispatch_hold), 64'd1);
      // Reset in the second DRAIN cycle
      reset = 1'b1;
      tick();
      check("mr_hold", 64'(dispatch_hold), 64'd0);
      check("mr_redir_pc", 64'(redirect_pc), 64'd0);
      check("mr_state", 64'(dbg_state), 64'(S_RUN));
      check("mr_halted", 64'(halted), 64'd0);
      reset = 1'b0;
      set_slot(2, 5'd4, 6'd40, 1'b0, 1'b0, 32'h0);
      tick();
      check("mr_we", 64'(map_we), 64'b100);
      check("mr_arch2", 64'(map_arch[2]), 64'd4);
      check("mr_phys2", 64'(map_phys[2]), 64'd40);

      // Non-contiguous valid; invalid slot 1 carries a precise bit that must be ignored
      idle();
      set_slot(2, 5'd8, 6'd41, 1'b0, 1'b0, 32'h0);
      set_slot(0, 5'd9, 6'd50, 1'b1, 1'b0, 32'h3000);
      ret_precise[1] = 1'b1;
      ret_target_pc[1] = 32'hbad0;
      tick();
      check("nc_we", 64'(map_we), 64'b101);
      check("nc_phys0", 64'(map_phys[0]), 64'd50);
      check("nc_redir_pc", 64'(redirect_pc), 64'h3000);
      check("nc_recover", 64'(recover_en), 64'd1);
      idle();
      // DRAIN_CYCLES=2, sq idle: three DRAIN cycles then RUN
      for (int k = 0; k < 3; k++) begin
         tick();
         check("nc_drain_hold", 64'(dispatch_hold), 64'd1);
      end
      tick();
      check("nc_run_hold", 64'(dispatch_hold), 64'd0);
      check("nc_run_state", 64'(dbg_state), 64'(S_RUN));

      // Halt on slot 2 with precise on slots 1,0
      idle();
      set_slot(2, 5'd1, 6'd60, 1'b0, 1'b1, 32'h0);
      set_slot(1, 5'd2, 6'd61, 1'b1, 1'b0, 32'h5000);
      set_slot(0, 5'd3, 6'd62, 1'b1, 1'b0, 32'h6000);
      tick();
      check("h_halted", 64'(halted), 64'd1);
      check("h_recover", 64'(recover_en), 64'd0);
      check("h_we", 64'(map_we), 64'b100);
      check("h_hold", 64'(dispatch_hold), 64'd1);
      check("h_state", 64'(dbg_state), 64'(S_HALT));
      for (int k = 0; k < 20; k++) begin
         idle();
         set_slot(k % 3, 5'(k + 1), 6'(k + 2), 1'b1, 1'b0, 32'(k));
         tick();
         check("h_stay_halted", 64'(halted), 64'd1);
         check("h_stay_we", 64'(map_we), 64'd0);
         check("h_stay_recover", 64'(recover_en), 64'd0);
      end
      do_reset();
      check("h_rst_halted", 64'(halted), 64'd0);
      check("h_rst_hold", 64'(dispatch_hold), 64'd0);

      // Older precise beats younger halt
      idle();
      set_slot(2, 5'd11, 6'd12, 1'b1, 1'b0, 32'h4000);
      set_slot(1, 5'd13, 6'd14, 1'b0, 1'b1, 32'h0);
      tick();
      check("ph_recover", 64'(recover_en), 64'd1);
      check("ph_halted", 64'(halted), 64'd0);
      check("ph_we", 64'(map_we), 64'b100);
      check("ph_redir_pc", 64'(redirect_pc), 64'h4000);

`ifdef RETIRE_STATS_EN
      do_reset();
      for (int k = 0; k < 3; k++) begin
         idle();
         set_slot(2, 5'd1, 6'd1, 1'b0, 1'b0, 32'h0);
         set_slot(1, 5'd2, 6'd2, 1'b0, 1'b0, 32'h0);
         set_slot(0, 5'd3, 6'd3, (k == 2), 1'b0, 32'h7000);
         tick();
      end
      idle();
      for (int k = 0; k < 5; k++) tick();
      check("st_retired", stat_retired, 64'd9);
      check("st_recovers", 64'(stat_recovers), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/retire_ctrl.md
Name: retire_ctrl

Overview:
Commit-stage sequencer behind the 3-wide reorder buffer.
- Consumes the up-to-3 entries the ROB retires each cycle and commits their destinations to the architectural map table.
- Detects the oldest entry needing precise-state recovery, discards the younger slots, and runs the recovery sequence: flush pulse, PC redirect, drain wait.
- Holds front-end dispatch during recovery and latches program halt.

Parameters:
XLEN, 32, data/PC width
ARCH_W, 5, architectural register index width
PHYS_W, 6, physical register index width
DRAIN_CYCLES, 2, minimum cycles spent in DRAIN after the flush pulse (legal range 1..15)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
ret_valid  in  3  retiring slot valid; slot 2 oldest, slot 0 youngest
ret_arch  in  3x ARCH_W  destination architectural register per slot (0 = no write)
ret_phys  in  3x PHYS_W  destination physical register per slot
ret_precise  in  3  slot requires precise-state recovery (mispredict)
ret_target_pc  in  3x XLEN  correct next PC for a precise slot
ret_halt  in  3  slot is a halt instruction
sq_busy  in  1  store queue still writing committed stores to memory
map_we  out  3  architectural map write enable per slot
map_arch  out  3x ARCH_W  map write index per slot
map_phys  out  3x PHYS_W  map write data per slot
recover_en  out  1  one-cycle flush pulse to ROB, RS, store queue and rename
redirect_valid  out  1  one-cycle fetch redirect, coincident with recover_en
redirect_pc  out  XLEN  redirect target
dispatch_hold  out  1  stall dispatch; also forces ROB retirement inputs to be ignored
halted  out  1  sticky halt flag

Behaviour:
- Outputs are registered, with 1-cycle latency from the ret_* inputs. All outputs reset to 0. FSM resets to RUN.
- Oldest-first scan: effective slots run from slot 2 down to the first slot s that has ret_valid=1 and either ret_precise=1 or ret_halt=1, inclusive. Slots younger than s are discarded: no map write and no effect.
- Map write per effective slot i: map_we[i] = ret_valid[i] && ret_arch[i] != 0.
  - map_arch and map_phys are copied from the inputs.
  - When no write occurs, map_arch and map_phys are 0.
  - Valid bits are not required to be contiguous; an invalid slot is skipped.
- FSM states: RUN, RECOVER, DRAIN, HALT.
  - RUN: commit effective slots.
    - If slot s is precise (and not halt): next state RECOVER. redirect_pc is latched from ret_target_pc[s].
    - If slot s is halt: next state HALT. Precise is ignored on a halt slot.
    - If precise and halt appear on different slots, the older one wins.
  - RECOVER (exactly 1 cycle):
    - recover_en=1, redirect_valid=1, dispatch_hold=1.
    - ret_* inputs are ignored (the ROB is being flushed).
    - Next state DRAIN; drain counter loaded with DRAIN_CYCLES.
  - DRAIN:
    - dispatch_hold=1; ret_* inputs ignored.
    - Counter decrements every cycle and saturates at 0.
    - Exit to RUN in the cycle after counter==0 && sq_busy==0.
    - While sq_busy is high, remain in DRAIN indefinitely.
  - HALT:
    - halted=1 and dispatch_hold=1. The state is absorbing until reset.
    - Map writes from the halt cycle's older effective slots still occur.
- dispatch_hold is 0 in RUN. It rises in the same cycle recover_en rises and falls in the cycle RUN is re-entered.
- Back-to-back: a precise slot arriving in the first RUN cycle after DRAIN is honoured normally.
- Reset mid-recovery: returns to RUN, clears redirect_pc, the counter and halted.

Optional Feature:
RETIRE_STATS_EN. When defined, adds outputs:
- stat_retired (64 bits): counts effective valid slots committed, +0..3 per cycle.
- stat_recovers (32 bits): counts RECOVER entries.
- Both wrap modulo 2^width and reset to 0.

When undefined, these ports and counters are absent.

Test Plan:
- ret_valid=111, arch=(3,0,7), phys=(33,34,35), no precise -> next cycle map_we=101, map_arch[2]=3/map_phys[2]=33, map_arch[0]=7/map_phys[0]=35; dispatch_hold=0.
- ret_valid=111, ret_precise=010, target_pc[1]=0x1000 -> slots 2,1 written, slot 0 dropped. Next cycle: recover_en=1, redirect_pc=0x1000 for exactly 1 cycle, dispatch_hold=1.
- Recovery with sq_busy=1 held for 5 cycles (DRAIN_CYCLES=2) -> dispatch_hold stays 1 until the cycle after sq_busy falls, then 0. Inputs presented during DRAIN cause no map_we.
- ret_halt=100 with ret_precise=011 on the same cycle -> halted=1, no recover_en, map_we=000 for slots 1 and 0; halted stays 1 for 20 cycles until reset.
- Reset asserted in the second DRAIN cycle -> next cycle all outputs 0, FSM RUN; a subsequent commit of arch=4/phys=40 on slot 2 writes normally.
- With RETIRE_STATS_EN: 3 cycles of 3 valid slots plus one recovery -> stat_retired=9, stat_recovers=1.
